// File: rtl/pong_serve_ctrl.sv
// pong_serve_ctrl -- game-flow controller for the Pong core.
//
// Sequences attract mode, the pre-serve delay, live play and game over on a
// single system clock. Frame ticks pace the serve delay; ball-miss pulses
// award points and flip the serve direction toward the player who lost it.
//
// Ports:
//   CLK         system clock, all state updates on the rising edge
//   CLR_N       asynchronous active-low reset
//   FRAME_TICK  one-cycle pulse per video frame
//   COIN        start request (level or pulse), honoured only in attract mode
//   MISS_L      ball left the field on the left  (right player scores)
//   MISS_R      ball left the field on the right (left player scores)
//   SERVE       ball enabled, high only during live play
//   SERVE_SIDE  serve direction: 0 = toward left, 1 = toward right
//   ATTRACT     high while in attract mode
//   GAME_OVER   a player reached WIN_SCORE; cleared by the next COIN
//   SCORE_L     left player score
//   SCORE_R     right player score
module pong_serve_ctrl #(
  parameter int SERVE_DELAY_FRAMES = 64,
  parameter int WIN_SCORE          = 11,
  parameter int CNT_W              = 7
) (
  input  logic       CLK,
  input  logic       CLR_N,
  input  logic       FRAME_TICK,
  input  logic       COIN,
  input  logic       MISS_L,
  input  logic       MISS_R,
  output logic       SERVE,
  output logic       SERVE_SIDE,
  output logic       ATTRACT,
  output logic       GAME_OVER,
  output logic [3:0] SCORE_L,
  output logic [3:0] SCORE_R
);

  typedef enum logic [1:0] {
    ST_ATTRACT    = 2'd0,
    ST_SERVE_WAIT = 2'd1,
    ST_PLAY       = 2'd2
  } state_t;

  // Counter runs 0..SERVE_DELAY_FRAMES-1; the tick seen at the last value
  // releases the ball.
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SERVE_DELAY_FRAMES - 1);
  localparam logic [3:0]       WIN_VALUE = 4'(WIN_SCORE);

  generate
    if (SERVE_DELAY_FRAMES < 1 || SERVE_DELAY_FRAMES > (2 ** CNT_W)) begin : g_bad_delay
      $error("pong_serve_ctrl: SERVE_DELAY_FRAMES must be in 1..2**CNT_W");
    end
    if (WIN_SCORE < 1 || WIN_SCORE > 15) begin : g_bad_win
      $error("pong_serve_ctrl: WIN_SCORE must be in 1..15");
    end
  endgenerate

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       score_l, score_l_n;
  logic [3:0]       score_r, score_r_n;
  logic             serve_side, serve_side_n;
  logic             game_over, game_over_n;
  logic [3:0]       new_score;

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state      <= ST_ATTRACT;
      cnt        <= '0;
      score_l    <= 4'd0;
      score_r    <= 4'd0;
      serve_side <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      score_l    <= score_l_n;
      score_r    <= score_r_n;
      serve_side <= serve_side_n;
      game_over  <= game_over_n;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    score_l_n    = score_l;
    score_r_n    = score_r;
    serve_side_n = serve_side;
    game_over_n  = game_over;
    new_score    = 4'd0;

    case (state)
      ST_ATTRACT: begin
        // Scores stay visible after a game until a new one is started.
        if (COIN) begin
          state_n     = ST_SERVE_WAIT;
          cnt_n       = '0;
          score_l_n   = 4'd0;
          score_r_n   = 4'd0;
          game_over_n = 1'b0;
        end
      end

      ST_SERVE_WAIT: begin
        if (FRAME_TICK) begin
          if (cnt == CNT_LAST) begin
            state_n = ST_PLAY;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end

      ST_PLAY: begin
        if (MISS_L || MISS_R) begin
          // A simultaneous miss is credited to the right player only.
          if (MISS_L) begin
            new_score    = score_r + 4'd1;
            score_r_n    = new_score;
            serve_side_n = 1'b0;
          end else begin
            new_score    = score_l + 4'd1;
            score_l_n    = new_score;
            serve_side_n = 1'b1;
          end

          if (new_score == WIN_VALUE) begin
            state_n     = ST_ATTRACT;
            game_over_n = 1'b1;
          end else begin
            state_n = ST_SERVE_WAIT;
            cnt_n   = '0;
          end
        end
      end

      default: begin
        state_n = ST_ATTRACT;
        cnt_n   = '0;
      end
    endcase
  end

  assign SERVE      = (state == ST_PLAY);
  assign ATTRACT    = (state == ST_ATTRACT);
  assign SERVE_SIDE = serve_side;
  assign GAME_OVER  = game_over;
  assign SCORE_L    = score_l;
  assign SCORE_R    = score_r;

endmodule
